// File: rtl/avalon_pio_edge_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO block: word address, select, write strobe and data.
// readdata is the only slave-driven signal.
interface avalon_pio_edge_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_edge_ctrl.sv
// Parametrised Avalon-MM PIO: output register with atomic set/clear, synchronised inputs
// with sticky per-bit edge capture, and a maskable level interrupt.
module avalon_pio_edge_ctrl #(
  parameter int unsigned               DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]     OUT_RESET   = '0,
  parameter int unsigned               EDGE_TYPE   = 0,
  parameter int unsigned               SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_edge_ctrl_if.slave bus,
  output logic [DATA_WIDTH-1:0] out_port,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_INPUT  = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic                                  wr;
  logic [DATA_WIDTH-1:0]                 wd;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0]                 sync_last;
  logic [DATA_WIDTH-1:0]                 hist_q, hist_d;
  logic [DATA_WIDTH-1:0]                 out_q, out_d;
  logic [DATA_WIDTH-1:0]                 mask_q, mask_d;
  logic [DATA_WIDTH-1:0]                 cap_q, cap_d;
  logic [DATA_WIDTH-1:0]                 cap_clr;
  logic [DATA_WIDTH-1:0]                 edge_det;
  logic [31:0]                           rd_data;
  logic                                  unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  // Upper writedata bits are intentionally dropped when DATA_WIDTH < 32.
  assign unused_wd = ^bus.writedata;

  // Input synchroniser chain; hist holds the previous value of the last stage.
  assign sync_d[0] = in_port;
  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign hist_d    = sync_last;

  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == 0) begin : g_rise
        assign edge_det[gi] = sync_last[gi] & ~hist_q[gi];
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_det[gi] = ~sync_last[gi] & hist_q[gi];
      end else begin : g_any
        assign edge_det[gi] = sync_last[gi] ^ hist_q[gi];
      end
    end
  endgenerate

  always_comb begin
    out_d   = out_q;
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:   out_d   = wd;
        ADDR_MASK:   mask_d  = wd;
        ADDR_EDGE:   cap_clr = wd;
        ADDR_OUTSET: out_d   = out_q | wd;
        ADDR_OUTCLR: out_d   = out_q & ~wd;
        default:     ;
      endcase
    end
    // A new edge wins over a simultaneous write-1-to-clear so no event is lost.
    cap_d = (cap_q & ~cap_clr) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= '0;
      out_q  <= OUT_RESET;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      out_q  <= out_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      ADDR_DATA:  rd_data[DATA_WIDTH-1:0] = out_q;
      ADDR_INPUT: rd_data[DATA_WIDTH-1:0] = sync_last;
      ADDR_MASK:  rd_data[DATA_WIDTH-1:0] = mask_q;
      ADDR_EDGE:  rd_data[DATA_WIDTH-1:0] = cap_q;
      default:    rd_data = '0;
    endcase
  end

  assign bus.readdata = rd_data;
  assign out_port     = out_q;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_edge_ctrl.sv
// Scoreboard bench: two PIO instances (rising-edge and any-edge capture) share identical
// bus and input stimulus; reads push expected values, a negedge monitor pops and compares.
module tb_avalon_pio_edge_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_port = 8'h00;
  logic [7:0] out0, out2;
  logic       irq0, irq2;

  int assertions = 0;
  int failures   = 0;

  avalon_pio_edge_ctrl_if bus0 ();
  avalon_pio_edge_ctrl_if bus2 ();

  avalon_pio_edge_ctrl #(
    .DATA_WIDTH(8), .OUT_RESET(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
    .out_port(out0), .in_port(in_port), .irq(irq0)
  );

  avalon_pio_edge_ctrl #(
    .DATA_WIDTH(8), .OUT_RESET(8'hA5), .EDGE_TYPE(2), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave),
    .out_port(out2), .in_port(in_port), .irq(irq2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic [7:0]  outp;
    logic        irq0;
    logic        irq2;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every read strobe is a DUT response to score.
  always @(negedge clk) begin
    if (bus0.chipselect && bus0.write_n) begin
      if (sb_q.size() == 0) begin
        assertions++;
        failures++;
        $display("FAIL unexpected_read: got read at addr %0d, expected none", bus0.address);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("read %-14s addr=%0d rd0=0x%08h rd2=0x%08h out0=0x%02h out2=0x%02h irq0=%0b irq2=%0b",
                 e.name, bus0.address, bus0.readdata, bus2.readdata, out0, out2, irq0, irq2);
        chk({e.name, ".rd0"},  bus0.readdata, e.rd0);
        chk({e.name, ".rd2"},  bus2.readdata, e.rd2);
        chk({e.name, ".out0"}, {24'h0, out0}, {24'h0, e.outp});
        chk({e.name, ".out2"}, {24'h0, out2}, {24'h0, e.outp});
        chk({e.name, ".irq0"}, {31'h0, irq0}, {31'h0, e.irq0});
        chk({e.name, ".irq2"}, {31'h0, irq2}, {31'h0, e.irq2});
      end
    end
  end

  task automatic set_bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = d;
    bus2.chipselect = cs; bus2.write_n = wn; bus2.address = a; bus2.writedata = d;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    $display("write addr=%0d data=0x%08h", a, d);
    set_bus(1'b1, 1'b0, a, d);
    step();
    set_bus(1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input string nm, input logic [31:0] r0, input logic [31:0] r2,
                    input logic [7:0] o, input logic i0, input logic i2);
    exp_t e;
    e.name = nm; e.rd0 = r0; e.rd2 = r2; e.outp = o; e.irq0 = i0; e.irq2 = i2;
    sb_q.push_back(e);
    set_bus(1'b1, 1'b1, a, 32'h0);
    step();
    set_bus(1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", assertions + 1, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    set_bus(1'b0, 1'b1, 3'd0, 32'h0);
    step();
    rd(0, "rst_hold_data", 32'hA5, 32'hA5, 8'hA5, 0, 0);
    reset_n = 1'b1;
    step();

    // Reset state
    rd(0, "rst_data", 32'hA5, 32'hA5, 8'hA5, 0, 0);
    rd(2, "rst_mask", 0, 0, 8'hA5, 0, 0);
    rd(3, "rst_edge", 0, 0, 8'hA5, 0, 0);
    rd(1, "rst_input", 0, 0, 8'hA5, 0, 0);
    rd(6, "rsvd6", 0, 0, 8'hA5, 0, 0);

    // Output data, set and clear
    wr(0, 32'h3C); rd(0, "data_3c", 32'h3C, 32'h3C, 8'h3C, 0, 0);
    wr(4, 32'h03); rd(0, "outset", 32'h3F, 32'h3F, 8'h3F, 0, 0);
    wr(5, 32'h0C); rd(0, "outclr", 32'h33, 32'h33, 8'h33, 0, 0);
    rd(4, "outset_rd0", 0, 0, 8'h33, 0, 0);
    rd(5, "outclr_rd0", 0, 0, 8'h33, 0, 0);
    wr(0, 32'hFFFFFF12); rd(0, "data_trunc", 32'h12, 32'h12, 8'h12, 0, 0);
    wr(1, 32'hFF); wr(6, 32'hFF); wr(7, 32'hFF);
    rd(0, "ignored_wr", 32'h12, 32'h12, 8'h12, 0, 0);
    rd(1, "input_ro", 0, 0, 8'h12, 0, 0);
    rd(7, "rsvd7", 0, 0, 8'h12, 0, 0);

    // Rising edge on bit 0 with mask bit 0: capture on the third edge
    wr(2, 32'h01); rd(2, "mask_01", 32'h01, 32'h01, 8'h12, 0, 0);
    in_port = 8'h01;
    rd(3, "edge0_c1", 0, 0, 8'h12, 0, 0);
    rd(3, "edge0_c2", 0, 0, 8'h12, 0, 0);
    rd(3, "edge0_c3", 0, 0, 8'h12, 0, 0);
    rd(3, "edge0_set", 32'h01, 32'h01, 8'h12, 1, 1);
    rd(1, "input_01", 32'h01, 32'h01, 8'h12, 1, 1);
    wr(3, 32'h01); rd(3, "edge0_clr", 0, 0, 8'h12, 0, 0);

    // Bit 2 edge lands in the same cycle as its clear: set wins
    in_port = 8'h05;
    idle(2);
    wr(3, 32'h04);
    rd(3, "set_wins", 32'h04, 32'h04, 8'h12, 0, 0);
    wr(2, 32'h04); rd(3, "mask_04_irq", 32'h04, 32'h04, 8'h12, 1, 1);
    rd(2, "mask_04", 32'h04, 32'h04, 8'h12, 1, 1);
    wr(2, 32'h00); rd(3, "mask_off_irq", 32'h04, 32'h04, 8'h12, 0, 0);
    wr(2, 32'h04);

    // Falling edge: only the any-edge instance captures it
    wr(3, 32'hFF); rd(3, "clr_all", 0, 0, 8'h12, 0, 0);
    in_port = 8'h25;
    idle(4);
    rd(3, "rise5", 32'h20, 32'h20, 8'h12, 0, 0);
    wr(3, 32'h20); rd(3, "rise5_clr", 0, 0, 8'h12, 0, 0);
    in_port = 8'h05;
    idle(4);
    rd(3, "fall5", 0, 32'h20, 8'h12, 0, 0);
    wr(2, 32'h20); rd(3, "fall5_irq", 0, 32'h20, 8'h12, 0, 1);
    in_port = 8'h00;
    idle(4);
    rd(3, "fall_02", 0, 32'h25, 8'h12, 0, 1);

    // One-cycle reset mid-operation
    reset_n = 1'b0;
    rd(3, "in_reset", 0, 0, 8'hA5, 0, 0);
    reset_n = 1'b1;
    rd(0, "post_rst_data", 32'hA5, 32'hA5, 8'hA5, 0, 0);
    rd(2, "post_rst_mask", 0, 0, 8'hA5, 0, 0);
    idle(4);
    rd(3, "post_rst_edge", 0, 0, 8'hA5, 0, 0);

    idle(2);
    assertions++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
